// File: rtl/xgmii_rx_tlp_extract.sv
// XGMII RX -> TLP FIFO writer: filters TLP-carrying Ethernet frames, strips
// preamble/MAC header/FCS and writes the TLP as tagged 64-bit words.
module xgmii_rx_tlp_extract #(
  parameter logic [15:0] ETHERTYPE    = 16'h88B5,
  parameter int          MAX_WORDS    = 34,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [47:0] if_macaddr,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  input  logic        prog_full,
  output logic [7:0]  xgmii_pktcount,
  output logic [15:0] rx_drop_count,
  output logic [15:0] rx_err_count
);

  localparam int            CW         = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LAST_SLOT  = CW'(MAX_WORDS - 1);
  localparam logic [63:0]   START_WORD = 64'hD555_5555_5555_55FB;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY0, PAY1, PAY, DROP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [47:0]   r_dst;
  logic [63:0]   r_hold;
  logic [CW-1:0] r_wcnt;
  logic [7:0]    r_pktCount;
  logic [15:0]   r_dropCount;
  logic [15:0]   r_errCount;

  logic        w_isStart, w_fdLane0, w_fdLane4, w_hasTerm, w_isIdle;
  logic        w_dstOk, w_accept;
  logic [47:0] w_dstNext;
  logic [15:0] w_etherType;
  logic        w_write, w_start, w_end, w_loadHold, w_dropInc, w_truncErr;
  logic [1:0]  w_keep;

  assign w_isStart   = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
  assign w_fdLane0   = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFD);
  assign w_fdLane4   = (xgmii_rxc == 8'hF0) && (xgmii_rxd[39:32] == 8'hFD) &&
                       (xgmii_rxd[63:40] == 24'h070707);
  assign w_isIdle    = (xgmii_rxc == 8'hFF);
  // First byte on the wire (lane 0) is the MSB of the MAC address.
  assign w_dstNext   = {xgmii_rxd[7:0], xgmii_rxd[15:8], xgmii_rxd[23:16],
                        xgmii_rxd[31:24], xgmii_rxd[39:32], xgmii_rxd[47:40]};
  assign w_etherType = {xgmii_rxd[39:32], xgmii_rxd[47:40]};
  assign w_dstOk     = (r_dst == if_macaddr) || (ACCEPT_BCAST && (r_dst == 48'hFFFF_FFFF_FFFF));
  assign w_accept    = w_dstOk && (w_etherType == ETHERTYPE) && (xgmii_rxc == 8'h00) && !prog_full;

  always_comb begin
    w_hasTerm = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == 8'hFD)) w_hasTerm = 1'b1;
    end
  end

  // The held word is written while its successor is on the bus, so the
  // successor decides whether the held word is the last one and how many dwords it keeps.
  always_comb begin
    w_next     = r_state;
    w_write    = 1'b0;
    w_start    = 1'b0;
    w_end      = 1'b0;
    w_keep     = 2'b11;
    w_loadHold = 1'b0;
    w_dropInc  = 1'b0;
    w_truncErr = 1'b0;
    case (r_state)
      IDLE: if (w_isStart) w_next = HDR0;
      HDR0: begin
        if (xgmii_rxc != 8'h00) begin
          w_next    = DROP;
          w_dropInc = 1'b1;
        end else begin
          w_next = HDR1;
        end
      end
      HDR1: begin
        if (w_accept) begin
          w_next = PAY0;
        end else begin
          w_next    = DROP;
          w_dropInc = 1'b1;
        end
      end
      PAY0: begin
        if (xgmii_rxc != 8'h00) begin
          w_next    = DROP;
          w_dropInc = 1'b1;
        end else begin
          w_loadHold = 1'b1;
          w_next     = PAY1;
        end
      end
      PAY1: begin
        if (xgmii_rxc != 8'h00) begin
          w_next    = DROP;
          w_dropInc = 1'b1;
        end else begin
          w_write    = 1'b1;
          w_start    = 1'b1;
          w_loadHold = 1'b1;
          w_next     = PAY;
        end
      end
      PAY: begin
        w_write = 1'b1;
        if (xgmii_rxc == 8'h00) begin
          w_loadHold = 1'b1;
        end else if (w_fdLane0) begin
          w_keep = 2'b01;
          w_end  = 1'b1;
          w_next = IDLE;
        end else if (w_fdLane4) begin
          w_end  = 1'b1;
          w_next = IDLE;
        end else begin
          w_end      = 1'b1;
          w_truncErr = 1'b1;
          w_next     = DROP;
        end
        if ((r_wcnt == LAST_SLOT) && !w_end) begin
          w_end      = 1'b1;
          w_truncErr = 1'b1;
          w_next     = DROP;
        end
      end
      DROP: if (w_hasTerm || w_isIdle) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_dst       <= '0;
      r_hold      <= '0;
      r_wcnt      <= '0;
      r_pktCount  <= '0;
      r_dropCount <= '0;
      r_errCount  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == HDR0) r_dst <= w_dstNext;
      if (w_loadHold) r_hold <= xgmii_rxd;
      if (r_state == HDR1) r_wcnt <= '0;
      else if (w_write) r_wcnt <= r_wcnt + CW'(1);
      if (w_write && w_end && !full) r_pktCount <= r_pktCount + 8'd1;
      if (w_dropInc) r_dropCount <= r_dropCount + 16'd1;
      r_errCount <= r_errCount + 16'(w_truncErr) + 16'(w_write & full);
    end
  end

  assign wr_en          = w_write & ~full;
  assign din            = wr_en ? {4'b0000, w_keep, w_end, w_start, r_hold} : 72'd0;
  assign xgmii_pktcount = r_pktCount;
  assign rx_drop_count  = r_dropCount;
  assign rx_err_count   = r_errCount;

endmodule
